renkon_ctrl_feed: RTL and testbench

Input-side sequencer for the renkon convolution core. It drives the ctrl_bus start/valid/stop stream and the first_input/last_input flags that the convolution controller consumes. It walks the input feature memory channel by channel in raster order, issuing read addresses. Control outputs are delayed by the memory read latency so that each valid pulse lines up with its pixel data.

---
 rtl/renkon_ctrl_feed_if.sv | 10 +
 rtl/renkon_ctrl_feed.sv | 210 +++++++++++++++++++++
 tb/tb_renkon_ctrl_feed.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/renkon_ctrl_feed_if.sv
// ctrl_bus: start/valid/stop stream from the renkon input sequencer to the
// convolution controller. The sequencer drives it through the "out" modport.
interface ctrl_bus;
  logic start;
  logic valid;
  logic stop;

  modport out (output start, output valid, output stop);
  modport in  (input  start, input  valid, input  stop);
endinterface

// File: rtl/renkon_ctrl_feed.sv
// renkon_ctrl_feed: input-side sequencer for the renkon convolution core.
// Walks the input feature memory channel by channel in raster order, issues
// read addresses, and emits the ctrl_bus start/valid/stop stream plus the
// first_input/last_input flags. The flags are delayed by the memory read
// latency D_MEM so that they line up with the returning pixel data.
// Optional build macro: RENKON_FEED_STALL_EN adds a 'stall' input that
// inserts bubbles while issuing.
module renkon_ctrl_feed #(
  parameter int LWIDTH  = 16,
  parameter int IMGSIZE = 12,
  parameter int D_MEM   = 2
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               req,
  input  logic [LWIDTH-1:0]  img_size,
  input  logic [LWIDTH-1:0]  n_in,
  input  logic [IMGSIZE-1:0] img_base,
`ifdef RENKON_FEED_STALL_EN
  input  logic               stall,
`endif
  ctrl_bus.out               out_ctrl,
  output logic               first_input,
  output logic               last_input,
  output logic               mem_img_re,
  output logic [IMGSIZE-1:0] mem_img_addr,
  output logic               busy,
  output logic               done
);

  localparam int DCW = (D_MEM > 1) ? $clog2(D_MEM) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN} state_t;

  // Per-issue flags travelling alongside the memory read.
  typedef struct packed {
    logic v;  // valid
    logic e;  // stop (last issue of the layer)
    logic f;  // channel 0
    logic l;  // channel n_in-1
  } flags_t;

  state_t             state;
  logic [LWIDTH-1:0]  size_m1;
  logic [LWIDTH-1:0]  nin_m1;
  logic [LWIDTH-1:0]  x_cnt;
  logic [LWIDTH-1:0]  y_cnt;
  logic [LWIDTH-1:0]  ch_cnt;
  logic [IMGSIZE-1:0] addr;
  logic [DCW-1:0]     drain_cnt;

  logic   stall_i;
  logic   issue;
  logic   last_pos;
  logic   iss_s;
  flags_t iss;
  flags_t pipe [D_MEM];
  flags_t tail;
  logic   hold_f;
  logic   hold_l;

`ifdef RENKON_FEED_STALL_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif

  assign issue    = (state == S_ISSUE) && !stall_i;
  assign last_pos = (x_cnt == size_m1) && (y_cnt == size_m1) && (ch_cnt == nin_m1);

  // Issue-stage flags; all zero on cycles that issue nothing (bubbles).
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    iss   = '0;
    iss_s = 1'b0;
    if (issue) begin
      iss.v = 1'b1;
      iss.e = last_pos;
      iss.f = (ch_cnt == '0);
      iss.l = (ch_cnt == nin_m1);
      iss_s = (ch_cnt == '0) && (x_cnt == '0) && (y_cnt == '0);
    end
  end

  // Sequencer FSM: load layer parameters, walk x/y/ch, drain the read latency.
  always_ff @(posedge clk) begin
    if (xrst) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values, independent of statement order.
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      size_m1   <= '0;
      nin_m1    <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      ch_cnt    <= '0;
      addr      <= '0;
      drain_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // A req landing on the done cycle is dropped: the layer is still closing.
          if (req && !done) begin
            state   <= S_LOAD;
            busy    <= 1'b1;
            size_m1 <= img_size - LWIDTH'(1);
            nin_m1  <= n_in - LWIDTH'(1);
            addr    <= img_base;
          end else begin
            busy <= 1'b0;
          end
        end
        S_LOAD: begin
          x_cnt  <= '0;
          y_cnt  <= '0;
          ch_cnt <= '0;
          state  <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!stall_i) begin
            // Channels are contiguous in memory, so a plain increment walks them.
            addr <= addr + IMGSIZE'(1);
            if (last_pos) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end else if (x_cnt == size_m1) begin
              x_cnt <= '0;
              if (y_cnt == size_m1) begin
                y_cnt  <= '0;
                ch_cnt <= ch_cnt + LWIDTH'(1);
              end else begin
                y_cnt <= y_cnt + LWIDTH'(1);
              end
            end else begin
              x_cnt <= x_cnt + LWIDTH'(1);
            end
          end
        end
        S_DRAIN: begin
          // Final stop leaves the pipeline on the last drain cycle; done follows it.
          if (drain_cnt == DCW'(D_MEM - 1)) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Flag delay line matching the memory read latency.
  always_ff @(posedge clk) begin
    if (xrst) begin
      // NOTE: the delay line is reset (unlike a data RAM) so an aborted layer cannot leak a stray valid/stop afterwards.
      for (int i = 0; i < D_MEM; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= iss;
      for (int i = 1; i < D_MEM; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail = pipe[D_MEM-1];

  // Start fires one cycle ahead of the first valid.
  generate
    if (D_MEM == 1) begin : g_start_reg
      logic start_r;
      // With no delay stages, flag the first issue cycle directly from S_LOAD.
      always_ff @(posedge clk) begin
        if (xrst) start_r <= 1'b0;
        else      start_r <= (state == S_LOAD);
      end
      assign out_ctrl.start = start_r;
    end else begin : g_start_pipe
      logic [D_MEM-2:0] s_sr;
      // Start pulse delayed by D_MEM-1 stages.
      always_ff @(posedge clk) begin
        if (xrst) begin
          s_sr <= '0;
        end else begin
          s_sr[0] <= iss_s;
          for (int i = 1; i < D_MEM - 1; i++) s_sr[i] <= s_sr[i-1];
        end
      end
      assign out_ctrl.start = s_sr[D_MEM-2];
    end
  endgenerate

  // Hold the channel flags across bubbles; clear once the layer's stop passes.
  always_ff @(posedge clk) begin
    if (xrst) begin
      hold_f <= 1'b0;
      hold_l <= 1'b0;
    end else if (tail.v) begin
      hold_f <= tail.f && !tail.e;
      hold_l <= tail.l && !tail.e;
    end
  end

  assign out_ctrl.valid = tail.v;
  assign out_ctrl.stop  = tail.e;
  assign first_input    = tail.v ? tail.f : hold_f;
  assign last_input     = tail.v ? tail.l : hold_l;
  assign mem_img_re     = issue;
  assign mem_img_addr   = issue ? addr : '0;

endmodule

// File: tb/tb_renkon_ctrl_feed.sv
// Self-checking bench for renkon_ctrl_feed: one instance with D_MEM=2 and one
// with D_MEM=1, a scoreboard of expected read addresses and per-valid flags,
// a table of layer shapes, and hand-written abort/req-ignore/stall sequences.
module tb_renkon_ctrl_feed;
  localparam int LW = 16;
  localparam int IW = 12;

  logic          clk = 1'b0;
  logic          xrst;
  logic          req;
  logic [LW-1:0] img_size;
  logic [LW-1:0] n_in;
  logic [IW-1:0] img_base;
`ifdef RENKON_FEED_STALL_EN
  logic          stall;
`endif

  always #5 clk = ~clk;

  ctrl_bus bus_a ();
  ctrl_bus bus_b ();

  logic a_first, a_last, a_re, a_busy, a_done;
  logic b_first, b_last, b_re, b_busy, b_done;
  logic [IW-1:0] a_addr, b_addr;

  renkon_ctrl_feed #(.LWIDTH(LW), .IMGSIZE(IW), .D_MEM(2)) u_dut_a (
    .clk(clk), .xrst(xrst), .req(req), .img_size(img_size), .n_in(n_in),
    .img_base(img_base),
`ifdef RENKON_FEED_STALL_EN
    .stall(stall),
`endif
    .out_ctrl(bus_a), .first_input(a_first), .last_input(a_last),
    .mem_img_re(a_re), .mem_img_addr(a_addr), .busy(a_busy), .done(a_done)
  );

  renkon_ctrl_feed #(.LWIDTH(LW), .IMGSIZE(IW), .D_MEM(1)) u_dut_b (
    .clk(clk), .xrst(xrst), .req(req), .img_size(img_size), .n_in(n_in),
    .img_base(img_base),
`ifdef RENKON_FEED_STALL_EN
    .stall(stall),
`endif
    .out_ctrl(bus_b), .first_input(b_first), .last_input(b_last),
    .mem_img_re(b_re), .mem_img_addr(b_addr), .busy(b_busy), .done(b_done)
  );

  // Observed instance: 0 = D_MEM=2, 1 = D_MEM=1.
  logic          sel;
  logic          m_start, m_valid, m_stop, m_first, m_last, m_re, m_busy, m_done;
  logic [IW-1:0] m_addr;
  assign m_start = sel ? bus_b.start : bus_a.start;
  assign m_valid = sel ? bus_b.valid : bus_a.valid;
  assign m_stop  = sel ? bus_b.stop  : bus_a.stop;
  assign m_first = sel ? b_first : a_first;
  assign m_last  = sel ? b_last  : a_last;
  assign m_re    = sel ? b_re    : a_re;
  assign m_addr  = sel ? b_addr  : a_addr;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard.
  typedef struct packed {
    logic f;
    logic l;
    logic e;
  } exp_t;

  exp_t          exp_q  [$];
  logic [IW-1:0] addr_q [$];

  int cyc = 0;
  int n_valid, n_start, n_stop, n_done, n_reads;
  int first_read, last_read, first_valid, last_valid, stop_cyc, done_cyc;
  bit prev_start = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t          r;
    logic [IW-1:0] ea;
    if (m_re) begin
      n_reads++;
      if (first_read < 0) first_read = cyc;
      last_read = cyc;
      if (addr_q.size() == 0) check("read_unexpected", 1, 0);
      else begin
        ea = addr_q.pop_front();
        check("read_addr", 32'(m_addr), 32'(ea));
      end
    end
    if (m_valid) begin
      n_valid++;
      if (first_valid < 0) begin
        first_valid = cyc;
        check("start_one_before_first_valid", 32'(prev_start), 1);
      end
      last_valid = cyc;
      if (exp_q.size() == 0) check("valid_unexpected", 1, 0);
      else begin
        r = exp_q.pop_front();
        check("valid_first_last_stop", {29'd0, m_first, m_last, m_stop}, {29'd0, r});
      end
    end else if (m_stop) begin
      check("stop_without_valid", 1, 0);
    end
    if (m_start) n_start++;
    if (m_stop) begin n_stop++; stop_cyc = cyc; end
    if (m_done) begin n_done++; done_cyc = cyc; end
    prev_start = m_start;
  end

  task automatic clear_sb();
    exp_q.delete();
    addr_q.delete();
    n_valid = 0; n_start = 0; n_stop = 0; n_done = 0; n_reads = 0;
    first_read = -1; last_read = -1; first_valid = -1; last_valid = -1;
    stop_cyc = -1; done_cyc = -1;
  endtask

  task automatic start_layer(input int sz, input int nin, input int base, input logic s);
    exp_t r;
    sel = s;
    clear_sb();
    for (int c = 0; c < nin; c++)
      for (int p = 0; p < sz * sz; p++) begin
        r.f = (c == 0);
        r.l = (c == nin - 1);
        r.e = (c == nin - 1) && (p == sz * sz - 1);
        exp_q.push_back(r);
      end
    for (int i = 0; i < sz * sz * nin; i++) addr_q.push_back(IW'(base + i));
    img_size = LW'(sz);
    n_in     = LW'(nin);
    img_base = IW'(base);
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("done_within_budget", 32'(n_done > 0), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_layer(input int nv, input int d, input int read_span);
    check("valid_count", 32'(nv > 0 ? n_valid : -1), 32'(nv));
    check("read_count", 32'(n_reads), 32'(nv));
    check("start_count", 32'(n_start), 1);
    check("stop_count", 32'(n_stop), 1);
    check("done_count", 32'(n_done), 1);
    check("read_to_valid_latency", 32'(first_valid - first_read), 32'(d));
    check("done_after_stop", 32'(done_cyc - stop_cyc), 1);
    check("read_span", 32'(last_read - first_read + 1), 32'(read_span));
    check("sb_empty", 32'(exp_q.size() + addr_q.size()), 0);
    check("idle_after_layer", 32'(m_busy), 0);
  endtask

  typedef struct {
    int   sz;
    int   nin;
    int   base;
    logic d1;
    int   exp_valids;
  } vec_t;

  initial begin
    vec_t vecs [6];
    int   k;
    vecs[0] = '{sz: 4, nin: 2, base: 'h100, d1: 1'b0, exp_valids: 32};
    vecs[1] = '{sz: 3, nin: 1, base: 'h200, d1: 1'b0, exp_valids: 9};
    vecs[2] = '{sz: 1, nin: 3, base: 'h050, d1: 1'b1, exp_valids: 3};
    vecs[3] = '{sz: 2, nin: 3, base: 'hFFE, d1: 1'b0, exp_valids: 12};
    vecs[4] = '{sz: 1, nin: 1, base: 'h7FF, d1: 1'b0, exp_valids: 1};
    vecs[5] = '{sz: 2, nin: 2, base: 'h300, d1: 1'b1, exp_valids: 8};

    sel = 1'b0;
    clear_sb();
    xrst = 1'b1; req = 1'b0; img_size = '0; n_in = '0; img_base = '0;
`ifdef RENKON_FEED_STALL_EN
    stall = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 xrst = 1'b0;
    @(negedge clk);
    check("reset_outputs_a", {12'd0, bus_a.start, bus_a.valid, bus_a.stop, a_first, a_last,
                              a_re, a_busy, a_done, a_addr}, 0);
    check("reset_outputs_b", {12'd0, bus_b.start, bus_b.valid, bus_b.stop, b_first, b_last,
                              b_re, b_busy, b_done, b_addr}, 0);

    // Table of layer shapes, consecutive reads expected.
    for (int i = 0; i < 6; i++) begin
      start_layer(vecs[i].sz, vecs[i].nin, vecs[i].base, vecs[i].d1);
      wait_done(300);
      check_layer(vecs[i].exp_valids, vecs[i].d1 ? 1 : 2, vecs[i].exp_valids);
    end

    // Second req 5 cycles after the first is ignored.
    start_layer(4, 1, 'h400, 1'b0);
    repeat (4) @(posedge clk);
    #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    check("busy_during_ignored_req", 32'(m_busy), 1);
    wait_done(300);
    check_layer(16, 2, 16);

    // Mid-layer reset: outputs clear at once, no stop/done, then clean restart.
    start_layer(4, 2, 'h500, 1'b0);
    repeat (10) @(posedge clk);
    #1 xrst = 1'b1;
    @(posedge clk); #1 xrst = 1'b0;
    @(negedge clk);
    check("abort_outputs_zero", {12'd0, bus_a.start, bus_a.valid, bus_a.stop, a_first, a_last,
                                 a_re, a_busy, a_done, a_addr}, 0);
    repeat (40) @(negedge clk);
    check("abort_no_stop", 32'(n_stop), 0);
    check("abort_no_done", 32'(n_done), 0);
    start_layer(4, 2, 'h500, 1'b0);
    wait_done(300);
    check_layer(32, 2, 32);

`ifdef RENKON_FEED_STALL_EN
    // Three stall cycles after the second read.
    start_layer(2, 1, 'h600, 1'b0);
    repeat (3) @(posedge clk);
    #1 stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    wait_done(300);
    check_layer(4, 2, 7);
    check("stall_valid_span", 32'(last_valid - first_valid), 6);
`endif

    // req coincident with done is dropped.
    start_layer(1, 1, 'h010, 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_done && k < 50);
    check("done_seen_for_coincident_req", 32'(m_done), 1);
    req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    check("req_on_done_not_busy", 32'(m_busy), 0);
    repeat (6) @(negedge clk);
    check("req_on_done_no_reads", 32'(n_reads), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
